// File: rtl/divider_16by8_pkg.sv
// div_pkg: shared widths, state encoding and constants for the 16-by-8 divider
//   DIVIDEND_W/DIVISOR_W : operand widths
//   QUOTIENT_W/REMAINDER_W : result widths
//   COUNT_W : width of the per-bit iteration counter
//   DZ_QUOTIENT : quotient returned on divide by zero
//   state_t : controller states
package div_pkg;
    localparam int DIVIDEND_W  = 16;
    localparam int DIVISOR_W   = 8;
    localparam int QUOTIENT_W  = DIVIDEND_W;
    localparam int REMAINDER_W = DIVISOR_W;
    localparam int COUNT_W     = 4;
    localparam logic [QUOTIENT_W-1:0] DZ_QUOTIENT = 16'hFFFF;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/divider_16by8_if.sv
// divider_16by8_if: start/done handshake and operand/result bus of the divider
//   master : drives start, a (dividend), b (divisor); observes results
//   slave  : the divider; drives q, r, dz, busy, done
interface divider_16by8_if;
    import div_pkg::*;
    logic                   start;
    logic [DIVIDEND_W-1:0]  a;
    logic [DIVISOR_W-1:0]   b;
    logic [QUOTIENT_W-1:0]  q;
    logic [REMAINDER_W-1:0] r;
    logic                   dz;
    logic                   busy;
    logic                   done;
    modport master (output start, a, b, input q, r, dz, busy, done);
    modport slave  (input start, a, b, output q, r, dz, busy, done);
endinterface

// File: rtl/divider_16by8_step.sv
// div_step: one restoring-division step (shift, trial compare, conditional subtract)
//   p       : partial remainder, always < b
//   qs      : dividend/quotient shift register
//   b       : divisor
//   p_next  : updated partial remainder
//   qs_next : shift register with the new quotient bit in its LSB
module div_step
    import div_pkg::*;
(
    input  logic [DIVISOR_W-1:0]  p,
    input  logic [DIVIDEND_W-1:0] qs,
    input  logic [DIVISOR_W-1:0]  b,
    output logic [DIVISOR_W-1:0]  p_next,
    output logic [DIVIDEND_W-1:0] qs_next
);
    logic [DIVISOR_W:0] t;
    logic               ge;
    // The trial value needs the 9th bit; the result is < b again so 8 bits hold it.
    always_comb begin
        t       = {p, qs[DIVIDEND_W-1]};
        ge      = t >= {1'b0, b};
        p_next  = ge ? DIVISOR_W'(t - {1'b0, b}) : t[DIVISOR_W-1:0];
        qs_next = {qs[DIVIDEND_W-2:0], ge};
    end
endmodule

// File: rtl/divider_16by8.sv
// divider_16by8: sequential restoring divider, 16-bit dividend / 8-bit divisor, one quotient bit per clock
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : divider_16by8_if.slave (start, a, b in; q, r, dz, busy, done out)
module divider_16by8
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    divider_16by8_if.slave  bus
);
    state_t                 state, state_next;
    logic [DIVIDEND_W-1:0]  qs, qs_next;
    logic [DIVISOR_W-1:0]   p, p_next, bs;
    logic [COUNT_W-1:0]     cnt;
    logic [QUOTIENT_W-1:0]  q;
    logic [REMAINDER_W-1:0] r;
    logic                   dz, accept, zero_div, last;

    // DONE returns to IDLE on the same edge that may take the next request,
    // so a held start repeats every 17 cycles.
    assign accept   = bus.start && state != RUN;
    assign zero_div = bus.b == '0;
    assign last     = state == RUN && cnt == '0;

    div_step u_step (
        .p       (p),
        .qs      (qs),
        .b       (bs),
        .p_next  (p_next),
        .qs_next (qs_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = accept ? (zero_div ? DONE : RUN)
                   : state == RUN ? (last ? DONE : RUN)
                   : IDLE;
    end

    always_comb begin
        bus.busy = state != IDLE;
        bus.done = state == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qs  <= '0;
            p   <= '0;
            bs  <= '0;
            cnt <= '0;
            q   <= '0;
            r   <= '0;
            dz  <= 1'b0;
        end else if (accept && zero_div) begin
            q  <= DZ_QUOTIENT;
            r  <= bus.a[REMAINDER_W-1:0];
            dz <= 1'b1;
        end else if (accept) begin
            qs  <= bus.a;
            bs  <= bus.b;
            p   <= '0;
            cnt <= COUNT_W'(DIVIDEND_W - 1);
            dz  <= 1'b0;
        end else if (state == RUN) begin
            qs  <= qs_next;
            p   <= p_next;
            cnt <= last ? '0 : cnt - 1'b1;
            // Results are published as the final step lands, so they are valid with done.
            if (last) begin
                q <= qs_next;
                r <= p_next;
            end
        end
    end

    assign bus.q  = q;
    assign bus.r  = r;
    assign bus.dz = dz;
endmodule
